game_sequencer: RTL

//  Top-level game controller for SkyHop; replaces the test-only FSM. Conditions btnU/btnL/btnR
//  (sync + debounce + press detect) and runs the game FSM. Drives the layer enables, jump pulses,

---
 rtl/game_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - SkyHop game controller: button conditioning and game state machine
module game_sequencer #(
    parameter int DEBOUNCE_MS     = 5,
    parameter int JUMP_TIMEOUT_MS = 2000,
    parameter int END_HOLD_MS     = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic one_ms_tick,
    input  logic btnU,
    input  logic btnL,
    input  logic btnR,
    input  logic jump_fail,
    input  logic time_elapsed,
    input  logic character_landed,
    output logic start_screen_en,
    output logic blocks_en,
    output logic time_bar_en,
    output logic character_en,
    output logic points_en,
    output logic end_screen_en,
    output logic bg_color_select,
    output logic jump_left,
    output logic jump_right,
    output logic timer_start,
    output logic led
);

    localparam int DB_W = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;

    typedef enum logic [1:0] {ST_START, ST_PLAY, ST_JUMP, ST_END} state_t;

    // Bit 0 = btnU, bit 1 = btnL, bit 2 = btnR throughout the button path
    logic [2:0] btn_raw;
    logic [2:0] sync_1;
    logic [2:0] sync_2;
    logic [2:0] deb;
    logic [2:0] deb_prev;
    logic [2:0] press;

    assign btn_raw = {btnR, btnL, btnU};

    // Two-flop synchronizer for the asynchronous buttons
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_btn
        if (DEBOUNCE_MS == 0) begin : g_bypass
            assign deb[i] = sync_2[i];
        end else begin : g_debounce
            logic            deb_r;
            logic [DB_W-1:0] cnt;

            // Accept a new level only after DEBOUNCE_MS consecutive ticks of disagreement
            always_ff @(posedge clk) begin
                if (rst) begin
                    deb_r <= 1'b0;
                    cnt   <= '0;
                end else if (sync_2[i] == deb_r) begin
                    cnt <= '0;
                end else if (one_ms_tick) begin
                    if (cnt == DB_W'(DEBOUNCE_MS - 1)) begin
                        deb_r <= sync_2[i];
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + DB_W'(1);
                    end
                end
            end

            assign deb[i] = deb_r;
        end
    end

    // Registered rising-edge detect: one-cycle press pulse after the debounced level rises
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_prev <= '0;
            press    <= '0;
        end else begin
            deb_prev <= deb;
            press    <= deb & ~deb_prev;
        end
    end

    state_t      state;
    state_t      state_nxt;
    logic [15:0] ms_cnt;
    logic [15:0] ms_inc;
    logic        timer_start_nxt;
    logic        jump_left_nxt;
    logic        jump_right_nxt;

    // Next-state and pulse decode; unconsumed presses simply fall away
    always_comb begin
        ms_inc          = (one_ms_tick && ms_cnt != 16'hFFFF) ? ms_cnt + 16'd1 : ms_cnt;
        state_nxt       = state;
        timer_start_nxt = 1'b0;
        jump_left_nxt   = 1'b0;
        jump_right_nxt  = 1'b0;
        case (state)
            ST_START: begin
                if (press[0]) begin
                    state_nxt       = ST_PLAY;
                    timer_start_nxt = 1'b1;
                end
            end
            ST_PLAY: begin
                if (time_elapsed) begin
                    state_nxt = ST_END;
                end else if (press[1] && !press[2]) begin
                    state_nxt     = ST_JUMP;
                    jump_left_nxt = 1'b1;
                end else if (press[2] && !press[1]) begin
                    state_nxt      = ST_JUMP;
                    jump_right_nxt = 1'b1;
                end
            end
            ST_JUMP: begin
                if (jump_fail) begin
                    state_nxt = ST_END;
                end else if (character_landed) begin
                    state_nxt       = ST_PLAY;
                    timer_start_nxt = 1'b1;
                end else if (ms_inc >= 16'(JUMP_TIMEOUT_MS)) begin
                    state_nxt = ST_END;
                end
            end
            ST_END: begin
                if (press[0] && ms_cnt >= 16'(END_HOLD_MS)) begin
                    state_nxt = ST_START;
                end
            end
            default: state_nxt = ST_START;
        endcase
    end

    // State, per-state ms counter and command pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_START;
            ms_cnt      <= '0;
            timer_start <= 1'b0;
            jump_left   <= 1'b0;
            jump_right  <= 1'b0;
        end else begin
            state       <= state_nxt;
            ms_cnt      <= (state_nxt != state) ? 16'd0 : ms_inc;
            timer_start <= timer_start_nxt;
            jump_left   <= jump_left_nxt;
            jump_right  <= jump_right_nxt;
        end
    end

    // Layer enables registered from the next state so they line up with the state register
    always_ff @(posedge clk) begin
        if (rst) begin
            start_screen_en <= 1'b1;
            blocks_en       <= 1'b0;
            time_bar_en     <= 1'b0;
            character_en    <= 1'b0;
            points_en       <= 1'b0;
            end_screen_en   <= 1'b0;
            bg_color_select <= 1'b0;
            led             <= 1'b0;
        end else begin
            start_screen_en <= (state_nxt == ST_START);
            blocks_en       <= (state_nxt == ST_PLAY) || (state_nxt == ST_JUMP);
            time_bar_en     <= (state_nxt == ST_PLAY) || (state_nxt == ST_JUMP);
            character_en    <= (state_nxt == ST_PLAY) || (state_nxt == ST_JUMP);
            points_en       <= (state_nxt != ST_START);
            end_screen_en   <= (state_nxt == ST_END);
            bg_color_select <= (state_nxt == ST_PLAY) || (state_nxt == ST_JUMP);
            led             <= (state_nxt == ST_JUMP);
        end
    end

endmodule
